// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive FIFO and its status consumers.
package uart_rx_fifo_pkg;

  // Default storage depth, independent of the UART baud rate.
  localparam int UART_FIFO_DEPTH = 64;
  localparam int UART_FIFO_LW    = $clog2(UART_FIFO_DEPTH) + 1;

  // Bundled status view for debug/status logic; the FIFO itself exposes separate ports.
  typedef struct packed {
    logic [UART_FIFO_LW-1:0] level;
    logic                    full;
    logic                    overflow;
    logic [7:0]              drop_count;
  } UartFifoStatus_t;

  // RTS hysteresis states: RTS_ON asserts rts_n low, RTS_OFF withdraws it.
  typedef enum logic {
    RTS_ON  = 1'b0,
    RTS_OFF = 1'b1
  } RxFifoRtsState_t;

endpackage

// File: rtl/fifo_byte_ram.sv
// Simple dual-port DEPTH x 8 RAM: one write port, one synchronous read port.
// Read returns the old contents on an address collision; written to map onto block RAM.
module fifo_byte_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port and registered read port share the single clock; no reset on storage.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO between the UART receiver and
// the VT100 parser. Holds pointers, head output register, status and RTS logic;
// storage lives in fifo_byte_ram.
// Optional feature macro: UART_FIFO_RTS_EN (RTS hysteresis FSM on rts_n).
//
// Output handshake: a byte transfers on any clock edge where out_valid and
// out_ready are both high; out_valid never falls and out_data never changes
// while out_valid is high and out_ready is low. in_valid has no ready: a byte
// offered while full without a same-cycle pop is dropped and counted.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int HIGH_MARK = 48,
  parameter int LOW_MARK  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  input  logic                   clr_overflow,
  output logic                   rts_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 4");
  end
  if (!(LOW_MARK < HIGH_MARK && HIGH_MARK <= DEPTH)) begin : g_bad_marks
    $error("uart_rx_fifo: requires LOW_MARK < HIGH_MARK <= DEPTH");
  end

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_nxt, rd_nxt, level_nxt;
  logic        pop, push, drop, byp_case;
  logic        byp_sel;
  logic [7:0]  byp_data;
  logic [7:0]  ram_q;

  // Transfer decisions and next pointer/level values for this cycle.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    wr_nxt    = wr_ptr + {{AW{1'b0}}, push};
    rd_nxt    = rd_ptr + {{AW{1'b0}}, pop};
    level_nxt = wr_nxt - rd_nxt;
    // The byte being written becomes the next head: the RAM read of that slot
    // would return stale data, so capture it directly into the head register.
    byp_case  = push && (rd_nxt == wr_ptr);
  end

  fifo_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_nxt[AW-1:0]),
    .rdata (ram_q)
  );

  // Pointers, registered status and the head-capture path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      out_valid <= 1'b0;
      byp_sel   <= 1'b0;
      byp_data  <= 8'h00;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      level     <= level_nxt;
      full      <= (level_nxt == DEPTH_LV);
      out_valid <= (level_nxt != '0);
      byp_sel   <= byp_case;
      if (byp_case) byp_data <= in_data;
    end
  end

  // Head byte: captured input right after a bypass, otherwise the prefetched RAM
  // word; forced to zero when empty so the RAM's unreset contents never show.
  assign out_data = out_valid ? (byp_sel ? byp_data : ram_q) : 8'h00;

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow)              drop_count <= 8'h01;
      else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'h01;
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end
  end

`ifdef UART_FIFO_RTS_EN
  localparam logic [LW-1:0] HIGH_LV = LW'(HIGH_MARK);
  localparam logic [LW-1:0] LOW_LV  = LW'(LOW_MARK);

  RxFifoRtsState_t rts_state, rts_state_nxt;

  // RTS state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rts_state <= RTS_ON;
    else     rts_state <= rts_state_nxt;
  end

  // Hysteresis: withdraw at the high mark, reassert at the low mark, judged on next level.
  always_comb begin
    rts_state_nxt = rts_state;
    case (rts_state)
      RTS_ON:  if (level_nxt >= HIGH_LV) rts_state_nxt = RTS_OFF;
      RTS_OFF: if (level_nxt <= LOW_LV)  rts_state_nxt = RTS_ON;
      default: rts_state_nxt = RTS_ON;
    endcase
  end

  assign rts_n = (rts_state == RTS_OFF);
`else
  assign rts_n = 1'b0;
`endif

endmodule
